// File: rtl/raizing_layer_mixer.sv
// raizing_layer_mixer: priority compositor for NUM_LAYERS layer pixels.
// Produces a palette index with a fixed three-tick latency on PIXEL_CEN,
// a frame-synchronised layer enable mask, a backdrop index and delayed blanking.
// Optional macro RAIZING_MIX_STATS_EN adds a per-frame backdrop pixel counter
// (output BACKDROP_COUNT).
module raizing_layer_mixer #(
  parameter int NUM_LAYERS = 4,
  parameter int PRI_W      = 4,
  parameter int IDX_W      = 11,
  localparam int PIXW      = PRI_W + IDX_W
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       PIXEL_CEN,
  input  logic                       ACTIVE,
  input  logic                       LHBL,
  input  logic                       LVBL,
  input  logic [NUM_LAYERS*PIXW-1:0] LAYER_PIXELS,
  input  logic [NUM_LAYERS-1:0]      MASK_DIN,
  input  logic                       MASK_WE,
  input  logic [IDX_W-1:0]           BACKDROP,
  output logic [IDX_W-1:0]           FINAL_PIXEL,
  output logic [3:0]                 WIN_LAYER,
`ifdef RAIZING_MIX_STATS_EN
  output logic [17:0]                BACKDROP_COUNT,
`endif
  output logic                       LHBL_DLY,
  output logic                       LVBL_DLY
);

  localparam logic [3:0] NO_LAYER = 4'hF;

  // Field extraction helpers for one packed layer pixel.
  function automatic logic [PRI_W-1:0] pix_pri(input logic [PIXW-1:0] pix);
    return pix[IDX_W +: PRI_W];
  endfunction

  function automatic logic [IDX_W-1:0] pix_idx(input logic [PIXW-1:0] pix);
    return pix[IDX_W-1:0];
  endfunction

  // Colour 0 of every 16-entry palette row is transparent.
  function automatic logic pix_opaque(input logic [PIXW-1:0] pix);
    return pix[3:0] != 4'd0;
  endfunction

  // Layer enable masks: shadow is written any time, active follows at vblank.
  logic [NUM_LAYERS-1:0] mask_sh_q;
  logic [NUM_LAYERS-1:0] mask_act_q;

  // Stage 1 registers.
  logic [NUM_LAYERS*PIXW-1:0] pix_p1_q;
  logic [NUM_LAYERS-1:0]      cand_p1_q;
  logic [NUM_LAYERS-1:0]      cand_d;
  logic                       act_p1_q;
  logic                       lhbl_p1_q;
  logic                       lvbl_p1_q;

  // Stage 2 registers.
  logic [IDX_W-1:0] idx_p2_q;
  logic [3:0]       win_p2_q;
  logic             act_p2_q;
  logic             lhbl_p2_q;
  logic             lvbl_p2_q;
  logic [IDX_W-1:0] idx_d;
  logic [3:0]       win_d;
  logic [PRI_W-1:0] sel_pri;
  logic             sel_found;

  // Stage 3 (output) registers.
  logic [IDX_W-1:0] fin_p3_q;
  logic [3:0]       win_p3_q;
  logic             lhbl_p3_q;
  logic             lvbl_p3_q;

  // Falling edge of vertical blank seen on a pixel tick.
  logic vbl_start;
  assign vbl_start = PIXEL_CEN && lvbl_p1_q && !LVBL;

  // Candidate flags: opaque pixel in a currently enabled layer.
  always_comb begin
    cand_d = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      cand_d[k] = mask_act_q[k] && pix_opaque(LAYER_PIXELS[k*PIXW +: PIXW]);
    end
  end

  // Mask double-buffer; a write on the vblank-start edge bypasses the shadow.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mask_sh_q  <= '1;
      mask_act_q <= '1;
    end else begin
      if (MASK_WE) mask_sh_q <= MASK_DIN;
      if (vbl_start) mask_act_q <= MASK_WE ? MASK_DIN : mask_sh_q;
    end
  end

  // ---- stage 1: capture pixels, qualifiers and candidate flags ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pix_p1_q  <= '0;
      cand_p1_q <= '0;
      act_p1_q  <= 1'b0;
      lhbl_p1_q <= 1'b0;
      lvbl_p1_q <= 1'b0;
    end else if (PIXEL_CEN) begin
      pix_p1_q  <= LAYER_PIXELS;
      cand_p1_q <= cand_d;
      act_p1_q  <= ACTIVE;
      lhbl_p1_q <= LHBL;
      lvbl_p1_q <= LVBL;
    end
  end

  // Highest priority candidate wins; strict compare keeps the lowest index on ties.
  always_comb begin
    idx_d     = BACKDROP;
    win_d     = NO_LAYER;
    sel_pri   = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (cand_p1_q[k] && (!sel_found || pix_pri(pix_p1_q[k*PIXW +: PIXW]) > sel_pri)) begin
        sel_found = 1'b1;
        sel_pri   = pix_pri(pix_p1_q[k*PIXW +: PIXW]);
        idx_d     = pix_idx(pix_p1_q[k*PIXW +: PIXW]);
        win_d     = 4'(k);
      end
    end
  end

  // ---- stage 2: register the winning index and layer number ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_p2_q  <= '0;
      win_p2_q  <= '0;
      act_p2_q  <= 1'b0;
      lhbl_p2_q <= 1'b0;
      lvbl_p2_q <= 1'b0;
    end else if (PIXEL_CEN) begin
      idx_p2_q  <= idx_d;
      win_p2_q  <= win_d;
      act_p2_q  <= act_p1_q;
      lhbl_p2_q <= lhbl_p1_q;
      lvbl_p2_q <= lvbl_p1_q;
    end
  end

  // ---- stage 3: outputs, forced to index 0 / no layer outside the display ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fin_p3_q  <= '0;
      win_p3_q  <= NO_LAYER;
      lhbl_p3_q <= 1'b0;
      lvbl_p3_q <= 1'b0;
    end else if (PIXEL_CEN) begin
      fin_p3_q  <= act_p2_q ? idx_p2_q : '0;
      win_p3_q  <= act_p2_q ? win_p2_q : NO_LAYER;
      lhbl_p3_q <= lhbl_p2_q;
      lvbl_p3_q <= lvbl_p2_q;
    end
  end

  assign FINAL_PIXEL = fin_p3_q;
  assign WIN_LAYER   = win_p3_q;
  assign LHBL_DLY    = lhbl_p3_q;
  assign LVBL_DLY    = lvbl_p3_q;

`ifdef RAIZING_MIX_STATS_EN
  logic [17:0] bd_cnt_q;
  logic [17:0] bd_count_q;

  // Count active backdrop pixels leaving stage 3; publish and clear at vblank.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bd_cnt_q   <= '0;
      bd_count_q <= '0;
    end else if (vbl_start) begin
      bd_count_q <= bd_cnt_q;
      bd_cnt_q   <= '0;
    end else if (PIXEL_CEN && act_p2_q && win_p2_q == NO_LAYER && bd_cnt_q != 18'h3FFFF) begin
      bd_cnt_q <= bd_cnt_q + 18'd1;
    end
  end

  assign BACKDROP_COUNT = bd_count_q;
`endif

endmodule

// File: tb/tb_raizing_layer_mixer.sv
// Bench for raizing_layer_mixer (NUM_LAYERS=4): fixed vector table, hand
// sequences for hold / mask / blanking / reset corners, and a random run
// compared against a queue-based reference model.
module tb_raizing_layer_mixer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        PIXEL_CEN = 1'b0;
  logic        ACTIVE = 1'b0;
  logic        LHBL = 1'b1;
  logic        LVBL = 1'b1;
  logic [59:0] LAYER_PIXELS = '0;
  logic [3:0]  MASK_DIN = '0;
  logic        MASK_WE = 1'b0;
  logic [10:0] BACKDROP = '0;
  logic [10:0] FINAL_PIXEL;
  logic [3:0]  WIN_LAYER;
  logic        LHBL_DLY;
  logic        LVBL_DLY;
`ifdef RAIZING_MIX_STATS_EN
  logic [17:0] BACKDROP_COUNT;
`endif

  raizing_layer_mixer #(.NUM_LAYERS(4), .PRI_W(4), .IDX_W(11)) dut (
    .CLK(CLK), .RESET(RESET), .PIXEL_CEN(PIXEL_CEN), .ACTIVE(ACTIVE),
    .LHBL(LHBL), .LVBL(LVBL), .LAYER_PIXELS(LAYER_PIXELS),
    .MASK_DIN(MASK_DIN), .MASK_WE(MASK_WE), .BACKDROP(BACKDROP),
    .FINAL_PIXEL(FINAL_PIXEL), .WIN_LAYER(WIN_LAYER),
`ifdef RAIZING_MIX_STATS_EN
    .BACKDROP_COUNT(BACKDROP_COUNT),
`endif
    .LHBL_DLY(LHBL_DLY), .LVBL_DLY(LVBL_DLY)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [10:0] pix;
    logic [3:0]  win;
    logic        act;
    logic        lhbl;
    logic        lvbl;
  } rec_t;

  typedef struct packed {
    logic [59:0] lp;
    logic        act;
    logic [10:0] bd;
    logic [10:0] e_pix;
    logic [3:0]  e_win;
  } vec_t;

  // Reference model state.
  rec_t        q[$];
  rec_t        cur;
  logic [3:0]  m_act, m_sh;
  logic        prev_lvbl;
  int unsigned bd_cnt, exp_bc;

  function automatic logic [14:0] lay(input logic [3:0] p, input logic [10:0] i);
    return {p, i};
  endfunction

  // Scan priorities from the top; first enabled opaque layer at that level wins.
  function automatic void ref_pick(input logic [59:0] lp, input logic [3:0] m,
                                   output logic [3:0] w, output logic [10:0] px);
    w = 4'hF;
    px = '0;
    for (int p = 15; p >= 0; p--)
      for (int k = 0; k < 4; k++)
        if (w == 4'hF && m[k] && lp[k*15 +: 4] != 4'd0 && int'(lp[k*15+11 +: 4]) == p) begin
          w = 4'(k);
          px = lp[k*15 +: 11];
        end
  endfunction

  function automatic rec_t reset_rec();
    rec_t r;
    r.pix = '0; r.win = 4'hF; r.act = 1'b0; r.lhbl = 1'b0; r.lvbl = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back(reset_rec());
    q.push_back(reset_rec());
    cur = reset_rec();
    m_act = 4'hF;
    m_sh = 4'hF;
    prev_lvbl = 1'b0;
    bd_cnt = 0;
    exp_bc = 0;
  endtask

  // Apply the effect of one CLK edge to the model (inputs as seen at the edge).
  task automatic model_edge(input logic cen);
    rec_t r, popped;
    logic vs;
    if (cen) begin
      ref_pick(LAYER_PIXELS, m_act, r.win, r.pix);
      r.act = ACTIVE; r.lhbl = LHBL; r.lvbl = LVBL;
      q.push_back(r);
      popped = q.pop_front();
      if (q[0].win == 4'hF) q[0].pix = BACKDROP;
      cur.pix  = popped.act ? popped.pix : 11'd0;
      cur.win  = popped.act ? popped.win : 4'hF;
      cur.lhbl = popped.lhbl;
      cur.lvbl = popped.lvbl;
      vs = prev_lvbl && !LVBL;
      if (vs) begin
        exp_bc = bd_cnt;
        bd_cnt = 0;
        m_act = MASK_WE ? MASK_DIN : m_sh;
      end else if (popped.act && popped.win == 4'hF && bd_cnt != 32'h3FFFF) begin
        bd_cnt++;
      end
      prev_lvbl = LVBL;
    end
    if (MASK_WE) m_sh = MASK_DIN;
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_model();
    chk("final_pixel", 32'(FINAL_PIXEL), 32'(cur.pix));
    chk("win_layer", 32'(WIN_LAYER), 32'(cur.win));
    chk("lhbl_dly", 32'(LHBL_DLY), 32'(cur.lhbl));
    chk("lvbl_dly", 32'(LVBL_DLY), 32'(cur.lvbl));
`ifdef RAIZING_MIX_STATS_EN
    chk("backdrop_count", 32'(BACKDROP_COUNT), exp_bc);
`endif
  endtask

  task automatic step(input logic cen);
    PIXEL_CEN = cen;
    @(posedge CLK);
    model_edge(cen);
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    PIXEL_CEN = 1'b0;
    @(posedge CLK);
    model_reset();
    #1;
    chk("reset_final", 32'(FINAL_PIXEL), 32'h0);
    chk("reset_win", 32'(WIN_LAYER), 32'hF);
    chk("reset_lhbl", 32'(LHBL_DLY), 32'h0);
    chk("reset_lvbl", 32'(LVBL_DLY), 32'h0);
    RESET = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    int lo_cnt, first_lo;

    vecs[0] = '{lp: {lay(4'hF, 11'h100), lay(4'h8, 11'h2A0), lay(4'h3, 11'h000), lay(4'h1, 11'h7F0)},
                act: 1'b1, bd: 11'h7F0, e_pix: 11'h7F0, e_win: 4'hF};
    vecs[1] = '{lp: {lay(4'h0, 11'h000), lay(4'h5, 11'h245), lay(4'h3, 11'h123), lay(4'h0, 11'h000)},
                act: 1'b1, bd: 11'h7F0, e_pix: 11'h245, e_win: 4'h2};
    vecs[2] = '{lp: {lay(4'h7, 11'h311), lay(4'h0, 11'h000), lay(4'h0, 11'h000), lay(4'h7, 11'h011)},
                act: 1'b1, bd: 11'h055, e_pix: 11'h011, e_win: 4'h0};
    vecs[3] = '{lp: {lay(4'h2, 11'h312), lay(4'h4, 11'h203), lay(4'h6, 11'h10C), lay(4'h9, 11'h0A1)},
                act: 1'b0, bd: 11'h055, e_pix: 11'h000, e_win: 4'hF};
    vecs[4] = '{lp: {lay(4'hF, 11'h400), lay(4'hE, 11'h3C1), lay(4'h2, 11'h005), lay(4'h2, 11'h0A1)},
                act: 1'b1, bd: 11'h111, e_pix: 11'h3C1, e_win: 4'h2};
    vecs[5] = '{lp: {lay(4'h1, 11'h00F), lay(4'h0, 11'h000), lay(4'h0, 11'h000), lay(4'h0, 11'h000)},
                act: 1'b1, bd: 11'h222, e_pix: 11'h00F, e_win: 4'h3};
    vecs[6] = '{lp: {lay(4'h0, 11'h301), lay(4'h0, 11'h201), lay(4'h0, 11'h101), lay(4'h0, 11'h001)},
                act: 1'b1, bd: 11'h333, e_pix: 11'h001, e_win: 4'h0};

    do_reset();
    LHBL = 1'b1;
    LVBL = 1'b1;

    // Table vectors: each held for three pixel ticks, then checked.
    for (int i = 0; i < 7; i++) begin
      LAYER_PIXELS = vecs[i].lp;
      ACTIVE = vecs[i].act;
      BACKDROP = vecs[i].bd;
      step(1'b1); step(1'b1); step(1'b1);
      chk($sformatf("vec%0d_pix", i), 32'(FINAL_PIXEL), 32'(vecs[i].e_pix));
      chk($sformatf("vec%0d_win", i), 32'(WIN_LAYER), 32'(vecs[i].e_win));
    end

    // Pixel enable held low for 5 CLKs in the middle of the pipeline.
    LAYER_PIXELS = vecs[1].lp;
    ACTIVE = 1'b1;
    BACKDROP = 11'h7F0;
    step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    step(1'b1);
    chk("hold_pix_early", 32'(FINAL_PIXEL), 32'h00F == 32'h0 ? 32'h0 : 32'(cur.pix));
    step(1'b1);
    chk("hold_pix", 32'(FINAL_PIXEL), 32'h245);
    chk("hold_win", 32'(WIN_LAYER), 32'h2);

    // Mid-frame mask write does not take effect until vblank start.
    LAYER_PIXELS = {lay(4'h0, 11'h000), lay(4'h3, 11'h2C3), lay(4'h8, 11'h1B2), lay(4'h9, 11'h0A1)};
    MASK_DIN = 4'b1110;
    MASK_WE = 1'b1;
    step(1'b1);
    MASK_WE = 1'b0;
    step(1'b1); step(1'b1); step(1'b1);
    chk("mask_midframe_win", 32'(WIN_LAYER), 32'h0);
    LVBL = 1'b0;
    step(1'b1);
    LVBL = 1'b1;
    step(1'b1); step(1'b1); step(1'b1);
    chk("mask_nextframe_win", 32'(WIN_LAYER), 32'h1);
    chk("mask_nextframe_pix", 32'(FINAL_PIXEL), 32'h1B2);
    // Write on the vblank-start edge applies at once.
    LVBL = 1'b0;
    MASK_DIN = 4'b1100;
    MASK_WE = 1'b1;
    step(1'b1);
    MASK_WE = 1'b0;
    LVBL = 1'b1;
    step(1'b1); step(1'b1); step(1'b1);
    chk("mask_same_edge_win", 32'(WIN_LAYER), 32'h2);
    chk("mask_same_edge_pix", 32'(FINAL_PIXEL), 32'h2C3);

    // Randomised run against the model.
    for (int i = 0; i < 600; i++) begin
      logic [59:0] lp;
      for (int k = 0; k < 4; k++) begin
        lp[k*15 +: 15] = 15'($urandom);
        lp[k*15+11 +: 4] = 4'($urandom_range(0, 3));
        if ($urandom_range(0, 9) < 3) lp[k*15 +: 4] = 4'd0;
      end
      LAYER_PIXELS = lp;
      ACTIVE = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) LHBL = ~LHBL;
      if ($urandom_range(0, 24) == 0) LVBL = ~LVBL;
      MASK_WE = ($urandom_range(0, 19) == 0);
      MASK_DIN = 4'($urandom);
      if ($urandom_range(0, 31) == 0) BACKDROP = 11'($urandom);
      step($urandom_range(0, 3) != 0);
    end
    MASK_WE = 1'b0;

    // LHBL low for 10 ticks shows up on LHBL_DLY delayed by the pipeline.
    LHBL = 1'b1;
    LVBL = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1);
    lo_cnt = 0;
    first_lo = -1;
    for (int i = 0; i < 20; i++) begin
      LHBL = (i >= 3 && i < 13) ? 1'b0 : 1'b1;
      step(1'b1);
      if (!LHBL_DLY) begin
        lo_cnt++;
        if (first_lo < 0) first_lo = i;
      end
    end
    chk("lhbl_pulse_len", 32'(lo_cnt), 32'd10);
    chk("lhbl_pulse_start", 32'(first_lo), 32'd5);

    // Reset with an opaque pixel in flight; mask returns to all ones.
    LHBL = 1'b1;
    LVBL = 1'b1;
    ACTIVE = 1'b1;
    MASK_DIN = 4'b0001;
    MASK_WE = 1'b1;
    LVBL = 1'b0;
    step(1'b1);
    MASK_WE = 1'b0;
    LVBL = 1'b1;
    LAYER_PIXELS = {lay(4'h0, 11'h000), lay(4'h3, 11'h2C3), lay(4'h8, 11'h1B2), lay(4'h9, 11'h0A1)};
    step(1'b1); step(1'b1);
    do_reset();
    step(1'b1); step(1'b1); step(1'b1);
    chk("post_reset_mask_win", 32'(WIN_LAYER), 32'h0);
    chk("post_reset_mask_pix", 32'(FINAL_PIXEL), 32'h0A1);

`ifdef RAIZING_MIX_STATS_EN
    // 100 active backdrop-only pixels in one frame.
    LAYER_PIXELS = '0;
    ACTIVE = 1'b0;
    LVBL = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1);
    LVBL = 1'b0;
    step(1'b1);
    LVBL = 1'b1;
    step(1'b1); step(1'b1);
    ACTIVE = 1'b1;
    for (int i = 0; i < 100; i++) step(1'b1);
    ACTIVE = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1);
    LVBL = 1'b0;
    step(1'b1);
    chk("stats_count", 32'(BACKDROP_COUNT), 32'd100);
    LVBL = 1'b1;
    step(1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
